// File: rtl/mp_window_gen.sv
// 2x2 stride-2 window producer: streams raster pixels, buffers one even row and emits one
// 512-bit window word (16 lanes of {br,bl,tr,tl} bytes) per window, with valid/ready on both sides.
module mp_window_gen #(
    parameter int unsigned IMG_W = 16,
    parameter int unsigned IMG_H = 16,
    parameter int unsigned COL_W = 9,
    parameter int unsigned ROW_W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_data,
    output logic         frame_done
);

    localparam int unsigned AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    typedef enum logic [1:0] {StFill, StPairL, StPairR} state_e;

    state_e         state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [127:0]   bl_q, bl_d;
    logic           out_valid_q, out_valid_d;
    logic [511:0]   out_data_q, out_data_d;
    logic           last_q, last_d;
    logic           frame_done_q, frame_done_d;

    logic [127:0]   linebuf [IMG_W];

    logic           in_xfer, out_xfer, col_wrap, row_last, load_win;
    logic [AW-1:0]  c_idx, c_prev;
    logic [127:0]   tl, tr;
    logic [511:0]   win;

    // Input is blocked whenever a pending window cannot leave, regardless of state.
    assign in_ready = !reset && (!out_valid_q || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;
    assign col_wrap = (col_q == COL_W'(IMG_W - 1));
    assign row_last = (row_q == ROW_W'(IMG_H - 1));
    assign load_win = in_xfer && (state_q == StPairR);

    assign c_idx  = col_q[AW-1:0];
    assign c_prev = c_idx - AW'(1);
    assign tl     = linebuf[c_prev];
    assign tr     = linebuf[c_idx];

    always_comb begin
        win = '0;
        for (int k = 0; k < 16; k++) begin
            win[32*k +: 32] = {in_data[8*k +: 8], bl_q[8*k +: 8], tr[8*k +: 8], tl[8*k +: 8]};
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        bl_d    = bl_q;
        if (in_xfer) begin
            col_d = col_wrap ? '0 : col_q + COL_W'(1);
            if (col_wrap) begin
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end
            case (state_q)
                StFill:  if (col_wrap) state_d = StPairL;
                StPairL: begin
                    bl_d    = in_data;
                    state_d = StPairR;
                end
                // Odd rows always end on an odd column, so a wrap here returns to an even row.
                StPairR: state_d = col_wrap ? StFill : StPairL;
                default: state_d = StFill;
            endcase
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        last_d       = last_q;
        frame_done_d = out_xfer && last_q;
        if (out_xfer) begin
            out_valid_d = 1'b0;
        end
        if (load_win) begin
            out_valid_d = 1'b1;
            out_data_d  = win;
            last_d      = col_wrap && row_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StFill;
            col_q        <= '0;
            row_q        <= '0;
            bl_q         <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            bl_q         <= bl_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer holds pixel data only; it is never cleared.
    always_ff @(posedge clk) begin
        if (in_xfer && (state_q == StFill)) begin
            linebuf[c_idx] <= in_data;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;

endmodule
